// File: rtl/async_fifo_core_pkg.sv
// Shared constants and word type for the NI flit staging FIFO.
package async_fifo_core_pkg;

    localparam int FIFO_LENGTH   = 32;
    localparam int FIFO_DEPTH    = 32;
    localparam int FIFO_MSB_SLOT = 4;

    typedef logic [FIFO_LENGTH-1:0] flit_t;

endpackage

// File: rtl/async_fifo_core_fifo_mem.sv
// DEPTH x LENGTH register file: one synchronous write port, one asynchronous read port.
module async_fifo_core_fifo_mem #(
    parameter int LENGTH   = 32,
    parameter int DEPTH    = 32,
    parameter int MSB_SLOT = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [MSB_SLOT:0]   waddr,
    input  logic [LENGTH-1:0]   wdata,
    input  logic [MSB_SLOT:0]   raddr,
    output logic [LENGTH-1:0]   rdata
);

    logic [LENGTH-1:0] mem_r [DEPTH];

    // Storage write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/async_fifo_core.sv
// Single-clock FWFT FIFO keeping the async_fifo port names; pointers carry one extra wrap bit.
module async_fifo_core
    import async_fifo_core_pkg::*;
#(
    parameter int LENGTH   = FIFO_LENGTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int MSB_SLOT = FIFO_MSB_SLOT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LENGTH-1:0]   wdata,
    input  logic                winc,
    output logic                wfull,
    input  logic                rinc,
    output logic [LENGTH-1:0]   rdata,
    output logic                rempty,
    output logic [MSB_SLOT+1:0] count
);

    localparam logic [MSB_SLOT+1:0] PTR_ONE = {{(MSB_SLOT+1){1'b0}}, 1'b1};

    logic [MSB_SLOT+1:0] wptr_r;
    logic [MSB_SLOT+1:0] rptr_r;
    logic                we_s;
    logic                re_s;
    logic [LENGTH-1:0]   mem_rdata_s;

    assign we_s = winc & ~wfull;
    assign re_s = rinc & ~rempty;

    // Pointer advance on accepted writes and reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (we_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (re_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Flags, occupancy and FWFT head word, all from the registered pointers.
    always_comb begin
        rempty = (wptr_r == rptr_r);
        wfull  = (wptr_r[MSB_SLOT:0] == rptr_r[MSB_SLOT:0]) &&
                 (wptr_r[MSB_SLOT+1] != rptr_r[MSB_SLOT+1]);
        count  = wptr_r - rptr_r;
        if (rempty) begin
            rdata = '0;
        end else begin
            rdata = mem_rdata_s;
        end
    end

    async_fifo_core_fifo_mem #(
        .LENGTH   (LENGTH),
        .DEPTH    (DEPTH),
        .MSB_SLOT (MSB_SLOT)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wptr_r[MSB_SLOT:0]),
        .wdata (wdata),
        .raddr (rptr_r[MSB_SLOT:0]),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_async_fifo_core.sv
// Randomized self-checking bench for async_fifo_core against a queue-based FIFO model.
module tb_async_fifo_core;

    logic        clk;
    logic        rst;
    logic [31:0] wdata;
    logic        winc;
    logic        wfull;
    logic        rinc;
    logic [31:0] rdata;
    logic        rempty;
    logic [5:0]  count;

    int          n_checks;
    int          n_fail;
    logic [31:0] model_q [$];

    async_fifo_core dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .winc   (winc),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_head();
        if (model_q.size() == 0) return 32'h0;
        return model_q[0];
    endfunction

    task automatic check_model(input string tag);
        check_eq({tag, "_count"},  {26'h0, count},  model_q.size());
        check_eq({tag, "_rempty"}, {31'h0, rempty}, {31'h0, model_q.size() == 0});
        check_eq({tag, "_wfull"},  {31'h0, wfull},  {31'h0, model_q.size() == 32});
        check_eq({tag, "_rdata"},  rdata,           model_head());
    endtask

    // Drive one cycle of requests, let the edge happen, then advance the model.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        bit do_w;
        bit do_r;
        do_w  = w && (model_q.size() < 32);
        do_r  = r && (model_q.size() > 0);
        winc  = w;
        rinc  = r;
        wdata = d;
        @(posedge clk);
        #1;
        if (do_r) void'(model_q.pop_front());
        if (do_w) model_q.push_back(d);
        winc  = 1'b0;
        rinc  = 1'b0;
    endtask

    initial begin
        int written;
        int cycles;
        logic w;
        logic r;
        n_checks = 0;
        n_fail   = 0;
        winc     = 1'b0;
        rinc     = 1'b0;
        wdata    = 32'h0;
        rst      = 1'b0;

        // Reset with no clock edge
        #1 rst = 1'b1;
        #2;
        check_eq("rst_rempty", {31'h0, rempty}, 32'h1);
        check_eq("rst_wfull",  {31'h0, wfull},  32'h0);
        check_eq("rst_count",  {26'h0, count},  32'h0);
        check_eq("rst_rdata",  rdata,           32'h0);
        rst = 1'b0;
        #1;
        check_model("rel");

        // Ordering
        step(1'b1, 1'b0, 32'h0000BBBB);
        check_eq("wr1_rdata", rdata, 32'h0000BBBB);
        step(1'b1, 1'b0, 32'h00010001);
        check_eq("wr2_count", {26'h0, count}, 32'd2);
        check_eq("wr2_rdata", rdata, 32'h0000BBBB);
        check_model("wr2");
        step(1'b0, 1'b1, 32'h0);
        check_eq("rd1_rdata", rdata, 32'h00010001);

        // Simultaneous access mid-queue
        step(1'b1, 1'b1, 32'h0100CCCC);
        check_eq("sim_count", {26'h0, count}, 32'd1);
        check_eq("sim_rdata", rdata, 32'h0100CCCC);
        step(1'b0, 1'b1, 32'h0);
        check_eq("sim_rempty", {31'h0, rempty}, 32'h1);
        check_model("sim");

        // Simultaneous access on empty: write only
        step(1'b1, 1'b1, 32'h0000E0E0);
        check_model("sim_empty");
        step(1'b0, 1'b1, 32'h0);

        // Fill and overflow
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, i);
        check_eq("full_wfull", {31'h0, wfull},  32'h1);
        check_eq("full_count", {26'h0, count},  32'd32);
        step(1'b1, 1'b0, 32'hDEADBEEF);
        check_model("ovf");
        for (int i = 0; i < 32; i++) begin
            check_eq("drain_rdata", rdata, i);
            step(1'b0, 1'b1, 32'h0);
        end
        check_eq("drain_rempty", {31'h0, rempty}, 32'h1);

        // Simultaneous access on full: read only
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 32'hA000_0000 + i);
        step(1'b1, 1'b1, 32'h5555AAAA);
        check_eq("simfull_count", {26'h0, count}, 32'd31);
        check_model("simfull");
        while (model_q.size() > 0) begin
            step(1'b0, 1'b1, 32'h0);
            check_model("simfull_drain");
        end

        // Underflow
        step(1'b0, 1'b1, 32'h0);
        check_model("udf");

        // Random interleave across pointer wrap
        written = 0;
        cycles  = 0;
        while ((written < 100 || model_q.size() > 0) && cycles < 5000) begin
            w = (written < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 2) != 0);
            if (w && model_q.size() < 32) written++;
            step(w, r, $urandom);
            check_model("rand");
            cycles++;
        end
        check_eq("rand_done", {31'h0, cycles < 5000}, 32'h1);

        // Reset between edges with data stored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h00C0_0000 + i);
        check_eq("pre_rst_count", {26'h0, count}, 32'd5);
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        check_eq("mid_rst_rempty", {31'h0, rempty}, 32'h1);
        check_eq("mid_rst_count",  {26'h0, count},  32'h0);
        check_eq("mid_rst_rdata",  rdata,           32'h0);
        #1 rst = 1'b0;
        step(1'b1, 1'b0, 32'h12345678);
        check_eq("post_rst_rdata", rdata, 32'h12345678);
        check_model("post_rst");
        step(1'b0, 1'b1, 32'h0);
        check_model("post_rst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
